spi_reg_bridge: RTL

- Parametrised SPI-slave-to-peripheral register bridge. It is the next-generation host test interface for TinyQV peripheral harnesses.
- Converts SPI frames into TinyQV-style peripheral bus strobes: address, data_in, data_write_n, data_read_n, data_out, data_ready.
- Over the previous fixed bridge it adds configurable address width, configurable synchroniser depth, burst auto-increment, a read turnaround, a data_ready timeout and a sticky error flag.
- Sits between the uio pins and the peripheral under test in standalone TT wrappers.

---
 rtl/spi_reg_bridge.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI mode-0 slave bridging frames onto TinyQV peripheral register strobes
module spi_reg_bridge #(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2,
    parameter bit BURST_EN    = 1'b1,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data_in,
    output logic [1:0]        data_write_n,
    output logic [1:0]        data_read_n,
    input  logic [31:0]       data_out,
    input  logic              data_ready,
    output logic              busy,
    output logic              err
);
    localparam int CMD_W = 3 + ADDR_W;
    localparam int CNT_W = $clog2(CMD_W + 33);
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_WAIT, RD_DATA, ABORT} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic                   cs_s, sck_s, mosi_s, cs_prev, sck_prev;
    logic                   cs_fall, sck_rise, sck_fall;

    logic [CMD_W-2:0]  cmd_sr;
    logic [CMD_W-1:0]  cmd_word;
    logic              cmd_rw;
    logic [1:0]        cmd_width;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  bit_cnt, data_bits_m1;
    logic [1:0]        width_q;
    logic [31:0]       width_mask, rd_word, tx_sr, load_word, load_aligned;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] addr_step;
    logic              cmd_last, data_last, dummy_done, rd_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b1;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync[0]   <= spi_cs_n;
            sck_sync[0]  <= spi_sck;
            mosi_sync[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cs_sync[i]   <= cs_sync[i-1];
                sck_sync[i]  <= sck_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            cs_prev  <= cs_s;
            sck_prev <= sck_s;
        end
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

    assign cmd_last   = (bit_cnt == CNT_W'(CMD_W - 1));
    assign data_last  = (bit_cnt == data_bits_m1);
    assign dummy_done = (bit_cnt == CNT_W'(8));
    assign rd_active  = (data_read_n != 2'b11);
    assign addr_step  = ADDR_W'(1) << width_q;

    always_comb begin
        cmd_word  = {cmd_sr, mosi_s};
        cmd_rw    = cmd_word[CMD_W-1];
        cmd_width = cmd_word[CMD_W-2 -: 2];
        cmd_addr  = cmd_word[ADDR_W-1:0];
        case (width_q)
            2'b00: begin
                data_bits_m1 = CNT_W'(7);
                width_mask   = 32'h0000_00FF;
            end
            2'b01: begin
                data_bits_m1 = CNT_W'(15);
                width_mask   = 32'h0000_FFFF;
            end
            default: begin
                data_bits_m1 = CNT_W'(31);
                width_mask   = 32'hFFFF_FFFF;
            end
        endcase
        // A read completing in the very cycle the word is needed is taken straight from the bus
        load_word = rd_active ? (data_out & width_mask) : rd_word;
        case (width_q)
            2'b00:   load_aligned = {load_word[7:0], 24'b0};
            2'b01:   load_aligned = {load_word[15:0], 16'b0};
            default: load_aligned = load_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && cs_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall) state_d = CMD;
                CMD: begin
                    if (sck_rise && cmd_last) begin
                        if (cmd_width == 2'b11) state_d = ABORT;
                        else if (cmd_rw)        state_d = WR_DATA;
                        else                    state_d = RD_WAIT;
                    end
                end
                WR_DATA: if (sck_rise && data_last && !BURST_EN) state_d = ABORT;
                RD_WAIT: if (sck_fall && dummy_done) state_d = RD_DATA;
                RD_DATA: if (sck_rise && data_last) state_d = BURST_EN ? RD_WAIT : ABORT;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address      <= '0;
            data_in      <= '0;
            data_write_n <= 2'b11;
            data_read_n  <= 2'b11;
            err          <= 1'b0;
            cmd_sr       <= '0;
            bit_cnt      <= '0;
            width_q      <= 2'b00;
            rd_word      <= '0;
            tx_sr        <= '0;
            to_cnt       <= '0;
        end else begin
            data_write_n <= 2'b11;
            // Address advances only after the write strobe cycle so it stays stable during it
            if (data_write_n != 2'b11 && BURST_EN) address <= address + addr_step;
            if (cs_s) begin
                if (state_q != IDLE) data_read_n <= 2'b11;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cs_fall) begin
                            err     <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            cmd_sr  <= cmd_word[CMD_W-2:0];
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (cmd_last) begin
                                bit_cnt <= '0;
                                width_q <= cmd_width;
                                address <= cmd_addr;
                                if (cmd_width == 2'b11) begin
                                    err <= 1'b1;
                                end else if (!cmd_rw) begin
                                    data_read_n <= cmd_width;
                                    to_cnt      <= '0;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sck_rise) begin
                            data_in <= (bit_cnt == '0) ? {31'b0, mosi_s} : {data_in[30:0], mosi_s};
                            if (data_last) begin
                                bit_cnt      <= '0;
                                data_write_n <= width_q;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    RD_WAIT: begin
                        if (rd_active) begin
                            if (data_ready) begin
                                rd_word     <= data_out & width_mask;
                                data_read_n <= 2'b11;
                            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                                rd_word     <= '0;
                                err         <= 1'b1;
                                data_read_n <= 2'b11;
                            end else begin
                                to_cnt <= to_cnt + TO_W'(1);
                            end
                        end
                        if (sck_rise && !dummy_done) bit_cnt <= bit_cnt + CNT_W'(1);
                        if (sck_fall && dummy_done) begin
                            bit_cnt     <= '0;
                            data_read_n <= 2'b11;
                            if (rd_active && !data_ready) begin
                                err   <= 1'b1;
                                tx_sr <= '0;
                            end else begin
                                tx_sr <= load_aligned;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sck_fall) tx_sr <= {tx_sr[30:0], 1'b0};
                        if (sck_rise) begin
                            if (data_last) begin
                                bit_cnt <= '0;
                                if (BURST_EN) begin
                                    address     <= address + addr_step;
                                    data_read_n <= width_q;
                                    to_cnt      <= '0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign spi_miso_oe = ((state_q == RD_WAIT) || (state_q == RD_DATA)) && !cs_s;
    assign spi_miso    = (state_q == RD_DATA) && !cs_s && tx_sr[31];
    assign busy        = !cs_s;
endmodule
